// File: rtl/aes_encrypt_if.sv
// Data bus of the AES-128 encryptor: plaintext and key in, ciphertext and completion flag out.
interface aes_encrypt_if;
    logic [127:0] Message;
    logic [127:0] Key;
    logic [127:0] cipher;
    logic         done;

    modport master (output Message, Key, input cipher, done);
    modport slave  (input Message, Key, output cipher, done);
endinterface

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion, result after NR edges.
// Optional macro AES_AUTO_RESTART_EN: a change of Message/Key after cycle 1 restarts the encryption.
module aes_encrypt #(
    parameter int NR = 10
) (
    input  logic clk,
    input  logic reset,
    aes_encrypt_if.slave bus
);

    localparam logic [3:0] RND_LAST = 4'(NR - 1);
    localparam logic [3:0] RND_DONE = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*(255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i of the block sits at bits [127-8i -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15 - (4*c + r)) +: 8] = sbox(s[8*(15 - (4*((c + r) % 4) + r)) +: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
    endfunction

    function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [127:0] cipher_q, cipher_d;
    logic         done_q, done_d;

    logic         start, restart;
    logic [127:0] key_src, key_nxt, round_full, round_final;

`ifdef AES_AUTO_RESTART_EN
    logic [127:0] msg_cp_q, key_cp_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            msg_cp_q <= '0;
            key_cp_q <= '0;
        end else if (start) begin
            msg_cp_q <= bus.Message;
            key_cp_q <= bus.Key;
        end
    end

    assign restart = (rnd_q != 4'd0) && ((bus.Message != msg_cp_q) || (bus.Key != key_cp_q));
`else
    assign restart = 1'b0;
`endif

    assign start   = (rnd_q == 4'd0) || restart;
    // One key-expansion datapath serves both the initial Key and the running round key.
    assign key_src = start ? bus.Key : key_q;
    assign key_nxt = expand_key(key_src, rcon(start ? 4'd0 : rnd_q));

    // The last cycle folds round NR-1 and the final round together so NR edges cover all rounds.
    assign round_full  = mix_columns(sub_shift(state_q)) ^ key_q;
    assign round_final = sub_shift(round_full) ^ key_nxt;

    always_comb begin
        rnd_d    = rnd_q;
        state_d  = state_q;
        key_d    = key_q;
        cipher_d = cipher_q;
        done_d   = done_q;
        if (start) begin
            state_d = bus.Message ^ bus.Key;
            key_d   = key_nxt;
            rnd_d   = 4'd1;
            done_d  = 1'b0;
        end else if (rnd_q < RND_LAST) begin
            state_d = round_full;
            key_d   = key_nxt;
            rnd_d   = rnd_q + 4'd1;
        end else if (rnd_q == RND_LAST) begin
            state_d  = round_final;
            key_d    = key_nxt;
            cipher_d = round_final;
            done_d   = 1'b1;
            rnd_d    = RND_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rnd_q    <= '0;
            state_q  <= '0;
            key_q    <= '0;
            cipher_q <= '0;
            done_q   <= 1'b0;
        end else begin
            rnd_q    <= rnd_d;
            state_q  <= state_d;
            key_q    <= key_d;
            cipher_q <= cipher_d;
            done_q   <= done_d;
        end
    end

    assign bus.cipher = cipher_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Scoreboard bench for aes_encrypt: expected ciphertexts are queued at issue and checked when done rises.
module tb_aes_encrypt;
    localparam int NR = 10;

    localparam logic [127:0] M1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] M2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] M3 = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] K3 = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] C3 = 128'h29c3505f571420f6402299b31a02d73a;

    logic clk = 1'b0;
    logic reset = 1'b0;

    aes_encrypt_if bus ();
    aes_encrypt #(.NR(NR)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int issue_edge = 0;
    logic [127:0] exp_q[$];
    logic [7:0] sb[256];
    logic done_prev = 1'b0;

    always @(posedge clk) if (reset) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [128:0] act, input logic [128:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box derived from the multiplicative inverse plus the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] m, input logic [127:0] k);
        logic [7:0] w[176];
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] tmp[4];
        logic [7:0] rc, x0, a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = k[127 - 8*i -: 8];
            s[i] = m[127 - 8*i -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                x0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x0];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] ^= w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*r + i];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    // Monitor: every rising done must match the oldest queued expectation and arrive NR edges after issue.
    always @(negedge clk) begin
        if (bus.done && !done_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {1'b1, bus.cipher}, 129'd0);
            end else begin
                check("cipher", {1'b0, bus.cipher}, {1'b0, exp_q.pop_front()});
                check("latency", 129'(edge_cnt - issue_edge), 129'(NR));
            end
        end
        done_prev = bus.done;
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles", exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    // Reset, drive inputs, release, check outputs stay clear through edge NR-1, then wait for the result.
    task automatic issue(input logic [127:0] m, input logic [127:0] k, input logic [127:0] e,
                         input bit scramble);
        reset = 1'b0;
        #1;
        check("rst_async", {bus.done, bus.cipher}, 129'd0);
        bus.Message = m;
        bus.Key = k;
        @(negedge clk);
        check("rst_state", {bus.done, bus.cipher}, 129'd0);
        exp_q.push_back(e);
        issue_edge = edge_cnt;
        reset = 1'b1;
        for (int e_i = 1; e_i < NR; e_i++) begin
            @(negedge clk);
`ifndef AES_AUTO_RESTART_EN
            if (scramble && e_i == 1) begin
                bus.Message = rand128();
                bus.Key = rand128();
            end
`endif
            check($sformatf("busy_e%0d", e_i), {bus.done, bus.cipher}, 129'd0);
        end
        wait_drain();
    endtask

    initial begin
        logic [127:0] m, k;
        bus.Message = '0;
        bus.Key = '0;
        build_sbox();
        repeat (2) @(negedge clk);

        issue(M1, K1, C1, 1'b0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("hold", {bus.done, bus.cipher}, {1'b1, C1});
        end

        bus.Message = M2;
        bus.Key = K2;
`ifdef AES_AUTO_RESTART_EN
        issue_edge = edge_cnt;
        exp_q.push_back(C2);
        @(negedge clk);
        check("restart_clear", {bus.done, bus.cipher}, {1'b0, C1});
        wait_drain();
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("ignore_change", {bus.done, bus.cipher}, {1'b1, C1});
        end
`endif

        issue(M2, K2, C2, 1'b1);
        issue(M3, K3, C3, 1'b1);

        // Abort mid-encryption, then a clean run of the same block.
        m = rand128();
        k = rand128();
        reset = 1'b0;
        bus.Message = m;
        bus.Key = k;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1 check("abort", {bus.done, bus.cipher}, 129'd0);
        issue(m, k, ref_aes(m, k), 1'b0);

        for (int n = 0; n < 4; n++) begin
            m = rand128();
            k = rand128();
            issue(m, k, ref_aes(m, k), n[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES rounds; only AES-128 (Nk=4, NR=10) is required.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Message, input, 128 bits: plaintext block; bit 127 is the MSB of byte 0.
REQ-005 SHALL have port Key, input, 128 bits: cipher key; bit 127 is the MSB of key byte 0.
REQ-006 SHALL have port cipher, output, 128 bits: registered ciphertext; same byte order as Message.
REQ-007 SHALL have port done, output, 1 bit: high while cipher holds a completed result.

Function
REQ-008 SHALL implement FIPS-197 AES-128 encryption: one AddRoundKey, NR-1 full rounds, one final round.
REQ-009 SHALL map state bytes column-major: Message byte 4c+r is state row r, column c.
REQ-010 Full round SHALL apply, in order, SubBytes, ShiftRows, MixColumns over GF(2^8) with polynomial 0x11B, then AddRoundKey.
REQ-011 Final round SHALL apply SubBytes, ShiftRows and AddRoundKey, with no MixColumns.
REQ-012 AddRoundKey SHALL be a 128-bit bitwise XOR of state and round key.
REQ-013 SHALL expand round keys on the fly, one round key per clock: RotWord, SubWord, XOR with Rcon, then the chained word XORs.
REQ-014 Rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-015 SHALL hold a round counter rnd, 4 bits, a 128-bit state register and a 128-bit round-key register.
REQ-016 Cycle 1 (rnd 0 to 1): state = Message ^ Key; round-key register = Key expanded to round key 1.
REQ-017 Cycles 2..NR-1 (rnd 1 to NR-1): state = full round using round key rnd; key register advances to round key rnd+1.
REQ-018 Cycle NR (rnd = NR-1 to NR): state = final round using round key NR; cipher loads the result; done becomes 1.
REQ-019 Latency SHALL be exactly NR rising edges after reset release.
REQ-020 Message and Key SHALL be sampled at the cycle-1 edge only; later changes SHALL be ignored unless AUTO_RESTART_EN is defined.
REQ-021 After completion, rnd SHALL saturate at NR, and cipher and done SHALL hold until reset.
REQ-022 cipher SHALL never expose intermediate round state; it changes only at completion.
REQ-023 S-box SHALL be the standard FIPS-197 table, shared by a combinational function across the 16 state bytes and the 4 key bytes.

Reset
REQ-024 While reset=0, rnd, the state register, the key register, cipher and done SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-025 Reset asserted mid-encryption SHALL abort it; after release the encryption restarts from cycle 1.
REQ-026 The first rising edge with reset=1 SHALL count as cycle 1.

Configuration
REQ-027 Macro AES_AUTO_RESTART_EN, when defined, SHALL register copies of Message and Key at cycle 1.
REQ-028 With AES_AUTO_RESTART_EN defined, any later difference between the inputs and those copies SHALL, at the next edge, act as cycle 1 of a new encryption with the current inputs.
REQ-029 On such a restart, done SHALL clear and cipher SHALL hold its old value until the new result loads NR cycles later.
REQ-030 Without AES_AUTO_RESTART_EN, no copy registers SHALL exist, and only reset restarts an encryption.

Verification
REQ-031 Message=3243F6A8885A308D313198A2E0370734, Key=2B7E151628AED2A6ABF7158809CF4F3C, release reset -> after 10 edges, cipher=3925841D02DC09FBDC118597196A0B32 and done=1.
REQ-032 Message=00112233445566778899AABBCCDDEEFF, Key=000102030405060708090A0B0C0D0E0F -> cipher=69C4E0D86A7B0430D8CDB78070B4C55A at edge 10.
REQ-033 Message=54776F204F6E65204E696E652054776F, Key=5468617473206D79204B756E67204675 -> cipher=29C3505F571420F6402299B31A02D73A; cipher=0 and done=0 on edges 1-9.
REQ-034 Assert reset low at edge 5, mid-encryption -> cipher=0 and done=0 immediately; release -> correct result 10 edges later.
REQ-035 Run for 30 edges after completion -> cipher and done remain stable.
REQ-036 With AES_AUTO_RESTART_EN: after the REQ-031 result, change Key to 000102030405060708090A0B0C0D0E0F and Message per REQ-032 -> done drops at the next edge and cipher=69C4E0D86A7B0430D8CDB78070B4C55A 10 edges later; without the macro, cipher is unchanged.
